// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: scoreboard entry layout,
// entry width helpers, bubble counter width and the all-zero bubble entry.
package hazard_pkg;

    // Flag bit positions inside one scoreboard entry
    localparam int E_VALID   = 0;
    localparam int E_RDWR    = 1;
    localparam int E_LOAD    = 2;
    localparam int E_MEMWR   = 3;
    localparam int E_FLAGS_W = 4;
    // Destination register index starts right after the flags; address follows it
    localparam int E_RD      = E_FLAGS_W;

    localparam int DEF_REG_W  = 3;
    localparam int DEF_ADDR_W = 16;
    localparam int BCNT_W     = 3;

    function automatic int entry_w(input int reg_w, input int addr_w);
        return E_FLAGS_W + reg_w + addr_w;
    endfunction

    function automatic int addr_off(input int reg_w);
        return E_RD + reg_w;
    endfunction

    // Entry width for the default register and address widths
    localparam int ENTRY_W = entry_w(DEF_REG_W, DEF_ADDR_W);

    // A bubble carries valid=0 and nothing else
    localparam logic [ENTRY_W-1:0] BUBBLE_ENTRY = '0;

endpackage

// File: rtl/hazard_entry_pipe.sv
// DEPTH x WIDTH shift register. Slot 0 is the youngest entry; every cycle each
// slot moves up one place and slot DEPTH-1 drops off. All slots are exposed
// on a flattened bus, slot k at bits [k*WIDTH +: WIDTH].
module hazard_entry_pipe #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       entry_i,
    output logic [DEPTH*WIDTH-1:0] entries_o
);

    logic [DEPTH*WIDTH-1:0] pipe_q;
    logic [DEPTH*WIDTH-1:0] pipe_d;

    // Next state: new entry into slot 0, every older slot moves up by one
    always_comb begin
        pipe_d = pipe_q;
        pipe_d[0 +: WIDTH] = entry_i;
        for (int k = 1; k < DEPTH; k++) begin
            pipe_d[k*WIDTH +: WIDTH] = pipe_q[(k-1)*WIDTH +: WIDTH];
        end
    end

    // State register; reset empties every slot (all-zero means valid=0)
    always_ff @(posedge clk) begin
        if (!rst) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign entries_o = pipe_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard between fetch and decode. Tracks in-flight destination
// registers and store addresses, flags RAW register hazards and memory
// hazards against the issuing instruction, and inserts BR_BUBBLES bubbles
// after an accepted jump/branch.
// Optional macro HAZ_FWD_EN: with full forwarding present only a load-use
// match on entry 0 raises haz_reg; the memory check is unchanged.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS   = 8,
    parameter int REG_W      = 3,
    parameter int DEPTH      = 4,
    parameter int ADDR_W     = 16,
    parameter int BR_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [REG_W-1:0]  rs_idx,
    input  logic              rs_used,
    input  logic [REG_W-1:0]  rt_idx,
    input  logic              rt_used,
    input  logic [REG_W-1:0]  rd_idx,
    input  logic              rd_wr,
    input  logic              is_load,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              is_ctrl,
    output logic              nop,
    output logic              pc_stall,
    output logic              haz_reg,
    output logic              haz_mem
);

    localparam int EW       = entry_w(REG_W, ADDR_W);
    localparam int ADDR_OFF = addr_off(REG_W);
    localparam logic [BCNT_W-1:0] BR_LOAD = BCNT_W'(BR_BUBBLES);

    if (REG_W != $clog2(NUM_REGS)) begin : g_bad_reg_w
        $error("hazard_scoreboard: REG_W must equal clog2(NUM_REGS)");
    end
    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("hazard_scoreboard: DEPTH must be 1..8");
    end
    if (BR_BUBBLES < 0 || BR_BUBBLES > 7) begin : g_bad_bubbles
        $error("hazard_scoreboard: BR_BUBBLES must be 0..7");
    end

    logic [EW-1:0]       entry_d;
    logic [DEPTH*EW-1:0] entries_w;
    logic [DEPTH-1:0]    ent_valid;
    logic [DEPTH-1:0]    ent_rdwr;
    logic [DEPTH-1:0]    ent_load;
    logic [DEPTH-1:0]    ent_memwr;
    logic [REG_W-1:0]    ent_rd   [DEPTH];
    logic [ADDR_W-1:0]   ent_addr [DEPTH];

    logic [BCNT_W-1:0]   bcnt_q;
    logic [BCNT_W-1:0]   bcnt_d;
    logic                bubble_act;
    logic                accept;

    assign bubble_act = (bcnt_q != '0);
    assign accept     = instr_valid & ~haz_reg & ~haz_mem & ~bubble_act;

    // Entry written into slot 0: the instruction when accepted, else a bubble
    always_comb begin
        entry_d = EW'(BUBBLE_ENTRY);
        if (accept) begin
            entry_d[E_VALID]            = 1'b1;
            entry_d[E_RDWR]             = rd_wr;
            entry_d[E_LOAD]             = is_load;
            entry_d[E_MEMWR]            = mem_wr;
            entry_d[E_RD +: REG_W]      = rd_idx;
            entry_d[ADDR_OFF +: ADDR_W] = mem_addr;
        end
    end

    hazard_entry_pipe #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .entry_i   (entry_d),
        .entries_o (entries_w)
    );

    // Split the flattened scoreboard into per-field views
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ent_valid[k] = entries_w[k*EW + E_VALID];
            ent_rdwr[k]  = entries_w[k*EW + E_RDWR];
            ent_load[k]  = entries_w[k*EW + E_LOAD];
            ent_memwr[k] = entries_w[k*EW + E_MEMWR];
            ent_rd[k]    = entries_w[k*EW + E_RD +: REG_W];
            ent_addr[k]  = entries_w[k*EW + ADDR_OFF +: ADDR_W];
        end
    end

`ifndef HAZ_FWD_EN
    // Without forwarding the load flag plays no part in register hazards
    logic unused_load;
    assign unused_load = ^ent_load;
`endif

    // Register and memory hazard comparators against every tracked entry
    always_comb begin
        haz_reg = 1'b0;
        haz_mem = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ent_valid[k] && ent_rdwr[k] &&
                ((rs_used && ent_rd[k] == rs_idx) || (rt_used && ent_rd[k] == rt_idx))) begin
`ifdef HAZ_FWD_EN
                // Everything except load-use on the youngest entry is forwarded
                if (k == 0 && ent_load[k]) begin
                    haz_reg = 1'b1;
                end
`else
                haz_reg = 1'b1;
`endif
            end
            if (ent_valid[k] && ent_memwr[k] && ent_addr[k] == mem_addr) begin
                haz_mem = 1'b1;
            end
        end
        haz_reg = haz_reg & instr_valid;
        haz_mem = haz_mem & instr_valid & (mem_rd | mem_wr);
    end

    // Bubble counter next state: reload on accepted control transfer, else count down
    always_comb begin
        bcnt_d = bcnt_q;
        if (accept && is_ctrl) begin
            bcnt_d = BR_LOAD;
        end else if (bubble_act) begin
            bcnt_d = bcnt_q - 1'b1;
        end
    end

    // Bubble counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            bcnt_q <= '0;
        end else begin
            bcnt_q <= bcnt_d;
        end
    end

    // An active bubble kills the fetch without holding the PC
    assign nop      = haz_reg | haz_mem | bubble_act;
    assign pc_stall = (haz_reg | haz_mem) & ~bubble_act;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int DEPTH      = 4;
    localparam int BR_BUBBLES = 2;
`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [2:0]  rs;
        logic        rs_used;
        logic [2:0]  rt;
        logic        rt_used;
        logic [2:0]  rd;
        logic        rd_wr;
        logic        load;
        logic        mem_rd;
        logic        mem_wr;
        logic [15:0] addr;
        logic        ctrl;
    } ins_t;

    typedef struct packed {
        int          cyc;
        logic [2:0]  rd;
        logic        rd_wr;
        logic        load;
        logic        mem_wr;
        logic [15:0] addr;
    } acc_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic [2:0]  rs_idx = '0, rt_idx = '0, rd_idx = '0;
    logic        rs_used = 1'b0, rt_used = 1'b0, rd_wr = 1'b0;
    logic        is_load = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0, is_ctrl = 1'b0;
    logic [15:0] mem_addr = '0;
    logic        nop, pc_stall, haz_reg, haz_mem;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .NUM_REGS   (8),
        .REG_W      (3),
        .DEPTH      (DEPTH),
        .ADDR_W     (16),
        .BR_BUBBLES (BR_BUBBLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .rs_idx      (rs_idx),
        .rs_used     (rs_used),
        .rt_idx      (rt_idx),
        .rt_used     (rt_used),
        .rd_idx      (rd_idx),
        .rd_wr       (rd_wr),
        .is_load     (is_load),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .is_ctrl     (is_ctrl),
        .nop         (nop),
        .pc_stall    (pc_stall),
        .haz_reg     (haz_reg),
        .haz_mem     (haz_mem)
    );

    // ---------------- scoreboard / reference model ----------------
    int   n_vec = 0;
    int   n_err = 0;
    acc_t acc_q[$];        // accepted instructions with their acceptance cycle
    int   cyc = 0;
    int   kill_until = -1; // fetches up to and including this cycle are killed
    bit   last_acc;
    logic obs_nop, obs_stall, obs_hreg, obs_hmem;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic ins_t idle();
        ins_t r;
        r = '0;
        return r;
    endfunction

    function automatic ins_t rand_ins();
        ins_t r;
        r         = '0;
        r.valid   = ($urandom_range(0, 9) < 8);
        r.rs      = 3'($urandom_range(0, 7));
        r.rs_used = 1'($urandom_range(0, 1));
        r.rt      = 3'($urandom_range(0, 7));
        r.rt_used = 1'($urandom_range(0, 1));
        r.rd      = 3'($urandom_range(0, 7));
        r.rd_wr   = 1'($urandom_range(0, 1));
        r.load    = ($urandom_range(0, 3) == 0);
        r.mem_rd  = r.load;
        r.mem_wr  = !r.load && ($urandom_range(0, 3) == 0);
        case ($urandom_range(0, 3))
            0:       r.addr = 16'h0040;
            1:       r.addr = 16'h0042;
            2:       r.addr = 16'h0044;
            default: r.addr = 16'($urandom);
        endcase
        r.ctrl    = ($urandom_range(0, 9) == 0);
        return r;
    endfunction

    // Drive one cycle, check all outputs against the model, advance the model
    task automatic step(input ins_t i, input logic rst_n);
        logic hr, hm, bub, acc;
        int   age;
        acc_t e;
        rst = rst_n;
        instr_valid = i.valid;
        rs_idx = i.rs; rs_used = i.rs_used;
        rt_idx = i.rt; rt_used = i.rt_used;
        rd_idx = i.rd; rd_wr = i.rd_wr;
        is_load = i.load; mem_rd = i.mem_rd; mem_wr = i.mem_wr;
        mem_addr = i.addr; is_ctrl = i.ctrl;
        @(negedge clk);
        while (acc_q.size() > 0 && cyc - acc_q[0].cyc > DEPTH) void'(acc_q.pop_front());
        hr = 1'b0;
        hm = 1'b0;
        if (i.valid) begin
            foreach (acc_q[k]) begin
                age = cyc - acc_q[k].cyc;
                if (acc_q[k].rd_wr && ((i.rs_used && acc_q[k].rd == i.rs) ||
                                       (i.rt_used && acc_q[k].rd == i.rt))) begin
                    if (!FWD || (age == 1 && acc_q[k].load)) hr = 1'b1;
                end
                if ((i.mem_rd || i.mem_wr) && acc_q[k].mem_wr && acc_q[k].addr == i.addr)
                    hm = 1'b1;
            end
        end
        bub = (cyc <= kill_until);
        obs_nop = nop; obs_stall = pc_stall; obs_hreg = haz_reg; obs_hmem = haz_mem;
        check("haz_reg",  haz_reg,  hr);
        check("haz_mem",  haz_mem,  hm);
        check("nop",      nop,      hr | hm | bub);
        check("pc_stall", pc_stall, (hr | hm) & !bub);
        acc = i.valid && !hr && !hm && !bub;
        if (!rst_n) begin
            acc_q.delete();
            kill_until = -1;
            last_acc = 1'b0;
        end else begin
            last_acc = acc;
            if (acc) begin
                e.cyc = cyc; e.rd = i.rd; e.rd_wr = i.rd_wr; e.load = i.load;
                e.mem_wr = i.mem_wr; e.addr = i.addr;
                acc_q.push_back(e);
                if (i.ctrl) kill_until = cyc + BR_BUBBLES;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Hold one instruction until accepted; count DUT stall and kill cycles
    task automatic issue(input ins_t i, output int stalls, output int kills);
        stalls = 0;
        kills  = 0;
        for (int n = 0; n < 12; n++) begin
            step(i, 1'b1);
            if (obs_stall) stalls++;
            if (obs_nop && !obs_stall) kills++;
            if (last_acc) break;
        end
        check("accepted", 32'(last_acc), 32'd1);
    endtask

    task automatic drain();
        repeat (DEPTH + BR_BUBBLES + 1) step(idle(), 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ins_t p, d;
        int   st, kl;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(idle(), 1'b0);
        step(idle(), 1'b1);

        // RAW on rs after a plain ALU producer
        p = idle(); p.valid = 1; p.rd = 3; p.rd_wr = 1;
        issue(p, st, kl);
        d = idle(); d.valid = 1; d.rs = 3; d.rs_used = 1;
        issue(d, st, kl);
        check("raw_stalls", st, FWD ? 0 : DEPTH);
        drain();

        // Load-use
        p = idle(); p.valid = 1; p.rd = 3; p.rd_wr = 1; p.load = 1; p.mem_rd = 1; p.addr = 16'h0010;
        issue(p, st, kl);
        issue(d, st, kl);
        check("load_use_stalls", st, FWD ? 1 : DEPTH);
        drain();

        // Store -> load same address
        p = idle(); p.valid = 1; p.mem_wr = 1; p.addr = 16'h0040;
        issue(p, st, kl);
        d = idle(); d.valid = 1; d.load = 1; d.mem_rd = 1; d.addr = 16'h0040;
        issue(d, st, kl);
        check("st_ld_stalls", st, DEPTH);
        drain();

        // Store -> load different address
        issue(p, st, kl);
        d.addr = 16'h0042;
        issue(d, st, kl);
        check("st_ld_diff_stalls", st, 0);
        drain();

        // Load -> load same address
        p = idle(); p.valid = 1; p.load = 1; p.mem_rd = 1; p.addr = 16'h0040;
        issue(p, st, kl);
        d.addr = 16'h0040;
        issue(d, st, kl);
        check("ld_ld_stalls", st, 0);
        drain();

        // Branch with no dependence: bubbles only
        p = idle(); p.valid = 1; p.ctrl = 1;
        issue(p, st, kl);
        d = idle(); d.valid = 1; d.rs = 5; d.rs_used = 1;
        issue(d, st, kl);
        check("br_kills", kl, BR_BUBBLES);
        check("br_stalls", st, 0);
        drain();

        // Branch that writes rd followed by a dependent: bubbles then stall
        p = idle(); p.valid = 1; p.ctrl = 1; p.rd = 5; p.rd_wr = 1;
        issue(p, st, kl);
        issue(d, st, kl);
        check("br_raw_kills", kl, BR_BUBBLES);
        check("br_raw_stalls", st, FWD ? 0 : DEPTH - BR_BUBBLES);
        drain();

        // Reset in the middle of a stall
        p = idle(); p.valid = 1; p.rd = 3; p.rd_wr = 1;
        issue(p, st, kl);
        d = idle(); d.valid = 1; d.rs = 3; d.rs_used = 1;
        step(d, 1'b1);
        step(d, 1'b0);
        step(d, 1'b1);
        check("rst_haz_reg", obs_hreg, 1'b0);
        check("rst_pc_stall", obs_stall, 1'b0);
        drain();

        // Unused source field must not match; used rt must
        p = idle(); p.valid = 1; p.rd = 6; p.rd_wr = 1;
        issue(p, st, kl);
        d = idle(); d.valid = 1; d.rs = 6; d.rs_used = 0; d.rt = 1; d.rt_used = 1;
        issue(d, st, kl);
        check("rs_unused_stalls", st, 0);
        drain();
        issue(p, st, kl);
        d = idle(); d.valid = 1; d.rt = 6; d.rt_used = 1;
        issue(d, st, kl);
        check("rt_used_stalls", st, FWD ? 0 : DEPTH);
        drain();

        // Simultaneous register and memory hazard
        p = idle(); p.valid = 1; p.rd = 2; p.rd_wr = 1; p.mem_wr = 1; p.addr = 16'h0044;
        issue(p, st, kl);
        d = idle(); d.valid = 1; d.rs = 2; d.rs_used = 1; d.mem_wr = 1; d.addr = 16'h0044;
        step(d, 1'b1);
        check("both_haz_mem", obs_hmem, 1'b1);
        check("both_haz_reg", obs_hreg, FWD ? 1'b0 : 1'b1);
        drain();

        // Randomised traffic, hold stalled instructions as fetch would
        d = rand_ins();
        for (int n = 0; n < 2000; n++) begin
            step(d, ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1);
            if (last_acc || !obs_stall) d = rand_ins();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
